demux_stream: RTL and testbench

- Parametrised 1:N streaming demultiplexer. It is the clocked, handshaked successor to the combinational 1:8 single-bit demux.
- It routes a W-bit word, tagged with a channel select, to one of N output channels. Each channel has a one-entry output register and a valid/ready handshake.
- It adds a broadcast mode, out-of-range select detection and a drop counter.
- It sits between a single producer and N independent consumers.

---
 rtl/demux_pkg.sv | 15 +
 rtl/demux_stream_if.sv | 29 ++
 rtl/demux_chan_reg.sv | 27 ++
 rtl/demux_stream.sv | 99 +++++++++
 tb/tb_demux_stream.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/demux_pkg.sv
// Shared definitions for the streaming 1:N demultiplexer.
package demux_pkg;

    // Default width of the saturating drop counter.
    localparam int unsigned DROP_CNTW = 8;

    // Saturation value of a default-width drop counter.
    localparam logic [DROP_CNTW-1:0] DROP_SAT = {DROP_CNTW{1'b1}};

    // Channel select width; never below one bit so N=2 still has a select line.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/demux_stream_if.sv
// Producer-side and consumer-side stream signals of the demultiplexer.
interface demux_stream_if
    import demux_pkg::*;
#(
    parameter int unsigned N    = 8,
    parameter int unsigned W    = 8,
    parameter int unsigned SELW = sel_width(N)
);
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    in_data;
    logic [SELW-1:0] in_sel;
    logic            in_bcast;
    logic [N-1:0]    out_valid;
    logic [N-1:0]    out_ready;
    logic [N*W-1:0]  out_data;

    // Demultiplexer view.
    modport slave (
        input  in_valid, in_data, in_sel, in_bcast, out_ready,
        output in_ready, out_valid, out_data
    );

    // Producer/consumer view.
    modport master (
        output in_valid, in_data, in_sel, in_bcast, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/demux_chan_reg.sv
// One-entry output register slice for a single demux channel.
module demux_chan_reg #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         pop,
    input  logic [W-1:0] d,
    output logic         full,
    output logic [W-1:0] q
);

    // Load wins over pop so a simultaneous pop+load keeps the slot full with the new word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
            q    <= '0;
        end else if (load) begin
            full <= 1'b1;
            q    <= d;
        end else if (pop) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_stream.sv
// Clocked, handshaked 1:N stream demultiplexer with broadcast and bad-select drop counting.
module demux_stream
    import demux_pkg::*;
#(
    parameter int unsigned N    = 8,
    parameter int unsigned W    = 8,
    parameter int unsigned CNTW = DROP_CNTW
) (
    input  logic            clk,
    input  logic            rst_n,
    demux_stream_if.slave   s,
    output logic            sel_err,
    output logic [CNTW-1:0] drop_cnt
);

    localparam int unsigned SELW = sel_width(N);
    localparam int unsigned SELN = 1 << SELW;

    logic [N-1:0]    full_v;
    logic [N-1:0]    pop_c;
    logic [N-1:0]    load_c;
    logic [N-1:0]    can_acc_c;
    logic [SELN-1:0] can_acc_pad_c;
    logic            full_q [N];
    logic [W-1:0]    data_q [N];
    logic [N*W-1:0]  out_data_c;
    logic            sel_ok_c;
    logic            in_ready_c;
    logic            fire_c;
    logic            drop_c;

    // A channel can take a word if empty or being drained this cycle.
    assign can_acc_c     = ~full_v | s.out_ready;
    assign pop_c         = full_v & s.out_ready;
    assign can_acc_pad_c = SELN'(can_acc_c);
    assign sel_ok_c      = (32'(s.in_sel) < 32'(N));

    // Select decode: broadcast needs every channel, unicast only its target, bad selects always drain.
    always_comb begin
        in_ready_c = 1'b1;
        if (s.in_bcast) begin
            in_ready_c = &can_acc_c;
        end else if (sel_ok_c) begin
            in_ready_c = can_acc_pad_c[s.in_sel];
        end
    end

    assign fire_c = s.in_valid & in_ready_c;
    assign drop_c = fire_c & ~s.in_bcast & ~sel_ok_c;

    // Per-channel load enables from the decoded select or broadcast.
    always_comb begin
        load_c = '0;
        for (int i = 0; i < int'(N); i++) begin
            load_c[i] = fire_c & (s.in_bcast | (sel_ok_c & (32'(s.in_sel) == 32'(i))));
        end
    end

    // One register slice per output channel.
    for (genvar g = 0; g < int'(N); g++) begin : g_chan
        demux_chan_reg #(.W(W)) u_chan (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (load_c[g]),
            .pop   (pop_c[g]),
            .d     (s.in_data),
            .full  (full_q[g]),
            .q     (data_q[g])
        );
    end

    // Pack channel state onto the flat output buses.
    always_comb begin
        full_v     = '0;
        out_data_c = '0;
        for (int i = 0; i < int'(N); i++) begin
            full_v[i]           = full_q[i];
            out_data_c[i*W +: W] = data_q[i];
        end
    end

    assign s.in_ready  = in_ready_c;
    assign s.out_valid = full_v;
    assign s.out_data  = out_data_c;

    // Bad-select pulse and saturating drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err  <= 1'b0;
            drop_cnt <= '0;
        end else begin
            sel_err <= drop_c;
            if (drop_c && (drop_cnt != {CNTW{1'b1}})) begin
                drop_cnt <= drop_cnt + CNTW'(1);
            end
        end
    end

endmodule

// File: tb/tb_demux_stream.sv
// Directed bench for demux_stream: an 8-channel and a 6-channel instance.
module tb_demux_stream;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sel_err8, sel_err6;
    logic [7:0] drop_cnt8, drop_cnt6;
    int         n_tests = 0;
    int         n_fail  = 0;

    demux_stream_if #(.N(8), .W(8)) bus8 ();
    demux_stream_if #(.N(6), .W(8)) bus6 ();

    demux_stream #(.N(8), .W(8), .CNTW(8)) dut8 (
        .clk      (clk),
        .rst_n    (rst_n),
        .s        (bus8.slave),
        .sel_err  (sel_err8),
        .drop_cnt (drop_cnt8)
    );

    demux_stream #(.N(6), .W(8), .CNTW(8)) dut6 (
        .clk      (clk),
        .rst_n    (rst_n),
        .s        (bus6.slave),
        .sel_err  (sel_err6),
        .drop_cnt (drop_cnt6)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus8.out_valid !== 8'h00) begin n_fail++; $display("FAIL reset_valid8: got %h expected %h", bus8.out_valid, 8'h00); end
        n_tests++;
        if (bus8.out_data !== 64'h0) begin n_fail++; $display("FAIL reset_data8: got %h expected %h", bus8.out_data, 64'h0); end
        n_tests++;
        if (sel_err8 !== 1'b0 || drop_cnt8 !== 8'h00) begin n_fail++; $display("FAIL reset_err8: got %b/%h expected 0/00", sel_err8, drop_cnt8); end
        n_tests++;
        if (bus6.out_valid !== 6'h00 || drop_cnt6 !== 8'h00 || sel_err6 !== 1'b0) begin n_fail++; $display("FAIL reset_dut6: got %h/%h/%b expected 00/00/0", bus6.out_valid, drop_cnt6, sel_err6); end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_unicast;
        bus8.out_ready = 8'hFF;
        bus8.in_bcast  = 1'b0;
        bus8.in_sel    = 3'd3;
        bus8.in_data   = 8'hA5;
        bus8.in_valid  = 1'b1;
        #1;
        n_tests++;
        if (bus8.in_ready !== 1'b1) begin n_fail++; $display("FAIL uni_ready: got %b expected 1", bus8.in_ready); end
        tick();
        bus8.in_valid = 1'b0;
        n_tests++;
        if (bus8.out_valid !== 8'b0000_1000) begin n_fail++; $display("FAIL uni_valid: got %b expected 00001000", bus8.out_valid); end
        n_tests++;
        if (bus8.out_data[3*8 +: 8] !== 8'hA5) begin n_fail++; $display("FAIL uni_data: got %h expected a5", bus8.out_data[3*8 +: 8]); end
        tick();
        n_tests++;
        if (bus8.out_valid !== 8'h00) begin n_fail++; $display("FAIL uni_drain: got %b expected 00000000", bus8.out_valid); end
    endtask

    task automatic test_stall;
        bus8.out_ready = 8'hDF;
        bus8.in_sel    = 3'd5;
        bus8.in_data   = 8'h11;
        bus8.in_valid  = 1'b1;
        #1;
        n_tests++;
        if (bus8.in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_first_ready: got %b expected 1", bus8.in_ready); end
        tick();
        // Unrelated channel keeps flowing while channel 5 is held.
        bus8.in_sel  = 3'd2;
        bus8.in_data = 8'h77;
        #1;
        n_tests++;
        if (bus8.in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_sel2_ready: got %b expected 1", bus8.in_ready); end
        tick();
        n_tests++;
        if (bus8.out_valid !== 8'b0010_0100 || bus8.out_data[2*8 +: 8] !== 8'h77) begin n_fail++; $display("FAIL stall_sel2_out: got %b/%h expected 00100100/77", bus8.out_valid, bus8.out_data[2*8 +: 8]); end
        bus8.in_sel  = 3'd5;
        bus8.in_data = 8'h22;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++;
            if (bus8.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready%0d: got %b expected 0", i, bus8.in_ready); end
            n_tests++;
            if (bus8.out_valid[5] !== 1'b1 || bus8.out_data[5*8 +: 8] !== 8'h11) begin n_fail++; $display("FAIL stall_hold%0d: got %b/%h expected 1/11", i, bus8.out_valid[5], bus8.out_data[5*8 +: 8]); end
            tick();
        end
        bus8.out_ready = 8'hFF;
        #1;
        n_tests++;
        if (bus8.in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release_ready: got %b expected 1", bus8.in_ready); end
        tick();
        bus8.in_valid = 1'b0;
        n_tests++;
        if (bus8.out_valid !== 8'b0010_0000 || bus8.out_data[5*8 +: 8] !== 8'h22) begin n_fail++; $display("FAIL stall_second: got %b/%h expected 00100000/22", bus8.out_valid, bus8.out_data[5*8 +: 8]); end
        tick();
        n_tests++;
        if (bus8.out_valid !== 8'h00) begin n_fail++; $display("FAIL stall_drain: got %b expected 00000000", bus8.out_valid); end
    endtask

    task automatic test_back_to_back;
        bus8.out_ready = 8'hFF;
        bus8.in_sel    = 3'd0;
        bus8.in_valid  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus8.in_data = 8'(i);
            #1;
            n_tests++;
            if (bus8.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready%0d: got %b expected 1", i, bus8.in_ready); end
            tick();
            n_tests++;
            if (bus8.out_valid !== 8'h01 || bus8.out_data[7:0] !== 8'(i)) begin n_fail++; $display("FAIL b2b_data%0d: got %b/%h expected 00000001/%h", i, bus8.out_valid, bus8.out_data[7:0], 8'(i)); end
        end
        bus8.in_valid = 1'b0;
        tick();
        n_tests++;
        if (bus8.out_valid !== 8'h00) begin n_fail++; $display("FAIL b2b_drain: got %b expected 00000000", bus8.out_valid); end
    endtask

    task automatic test_bcast;
        bus8.out_ready = 8'hBF;
        bus8.in_bcast  = 1'b0;
        bus8.in_sel    = 3'd6;
        bus8.in_data   = 8'h66;
        bus8.in_valid  = 1'b1;
        tick();
        bus8.in_bcast = 1'b1;
        bus8.in_sel   = 3'd1;
        bus8.in_data  = 8'h3C;
        #1;
        n_tests++;
        if (bus8.in_ready !== 1'b0) begin n_fail++; $display("FAIL bcast_blocked: got %b expected 0", bus8.in_ready); end
        tick();
        n_tests++;
        if (bus8.out_valid !== 8'h40 || bus8.out_data[6*8 +: 8] !== 8'h66) begin n_fail++; $display("FAIL bcast_wait: got %b/%h expected 01000000/66", bus8.out_valid, bus8.out_data[6*8 +: 8]); end
        bus8.out_ready = 8'hFF;
        #1;
        n_tests++;
        if (bus8.in_ready !== 1'b1) begin n_fail++; $display("FAIL bcast_ready: got %b expected 1", bus8.in_ready); end
        tick();
        bus8.in_valid = 1'b0;
        bus8.in_bcast = 1'b0;
        n_tests++;
        if (bus8.out_valid !== 8'hFF) begin n_fail++; $display("FAIL bcast_valid: got %b expected 11111111", bus8.out_valid); end
        n_tests++;
        if (bus8.out_data !== {8{8'h3C}}) begin n_fail++; $display("FAIL bcast_data: got %h expected %h", bus8.out_data, {8{8'h3C}}); end
        tick();
        n_tests++;
        if (bus8.out_valid !== 8'h00) begin n_fail++; $display("FAIL bcast_drain: got %b expected 00000000", bus8.out_valid); end
    endtask

    task automatic test_bad_sel;
        int exp_cnt;
        bus6.out_ready = 6'h3F;
        bus6.in_bcast  = 1'b0;
        bus6.in_sel    = 3'd7;
        bus6.in_valid  = 1'b1;
        for (int i = 0; i < 300; i++) begin
            bus6.in_data = 8'(i);
            #1;
            n_tests++;
            if (bus6.in_ready !== 1'b1) begin n_fail++; $display("FAIL bad_ready%0d: got %b expected 1", i, bus6.in_ready); end
            tick();
            exp_cnt = (i + 1 > 255) ? 255 : i + 1;
            n_tests++;
            if (sel_err6 !== 1'b1) begin n_fail++; $display("FAIL bad_err%0d: got %b expected 1", i, sel_err6); end
            n_tests++;
            if (bus6.out_valid !== 6'h00) begin n_fail++; $display("FAIL bad_valid%0d: got %b expected 000000", i, bus6.out_valid); end
            n_tests++;
            if (drop_cnt6 !== 8'(exp_cnt)) begin n_fail++; $display("FAIL bad_cnt%0d: got %h expected %h", i, drop_cnt6, 8'(exp_cnt)); end
        end
        bus6.in_valid = 1'b0;
        tick();
        n_tests++;
        if (sel_err6 !== 1'b0 || drop_cnt6 !== 8'hFF) begin n_fail++; $display("FAIL bad_idle: got %b/%h expected 0/ff", sel_err6, drop_cnt6); end
    endtask

    task automatic test_reset_mid;
        bus8.out_ready = 8'h00;
        bus8.in_bcast  = 1'b0;
        bus8.in_sel    = 3'd1;
        bus8.in_data   = 8'hC1;
        bus8.in_valid  = 1'b1;
        tick();
        bus8.in_sel  = 3'd4;
        bus8.in_data = 8'hC4;
        tick();
        bus8.in_valid = 1'b0;
        n_tests++;
        if (bus8.out_valid !== 8'b0001_0010) begin n_fail++; $display("FAIL mid_full: got %b expected 00010010", bus8.out_valid); end
        #1;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus8.out_valid !== 8'h00) begin n_fail++; $display("FAIL mid_async_valid: got %b expected 00000000", bus8.out_valid); end
        n_tests++;
        if (drop_cnt6 !== 8'h00) begin n_fail++; $display("FAIL mid_async_cnt: got %h expected 00", drop_cnt6); end
        #1;
        rst_n = 1'b1;
        bus8.out_ready = 8'hFF;
        bus8.in_sel    = 3'd4;
        bus8.in_data   = 8'h5A;
        bus8.in_valid  = 1'b1;
        tick();
        bus8.in_valid = 1'b0;
        n_tests++;
        if (bus8.out_valid !== 8'b0001_0000 || bus8.out_data[4*8 +: 8] !== 8'h5A) begin n_fail++; $display("FAIL mid_after: got %b/%h expected 00010000/5a", bus8.out_valid, bus8.out_data[4*8 +: 8]); end
        tick();
        n_tests++;
        if (bus8.out_valid !== 8'h00) begin n_fail++; $display("FAIL mid_drain: got %b expected 00000000", bus8.out_valid); end
    endtask

    initial begin
        bus8.in_valid  = 1'b0;
        bus8.in_data   = 8'h00;
        bus8.in_sel    = 3'd0;
        bus8.in_bcast  = 1'b0;
        bus8.out_ready = 8'h00;
        bus6.in_valid  = 1'b0;
        bus6.in_data   = 8'h00;
        bus6.in_sel    = 3'd0;
        bus6.in_bcast  = 1'b0;
        bus6.out_ready = 6'h00;
        test_reset();
        test_unicast();
        test_stall();
        test_back_to_back();
        test_bcast();
        test_bad_sel();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
